// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB-tag aliasing; reads are combinational with a commit bypass.
// Rename and commit update state on the rising edge. There is no backpressure: every input is accepted each cycle.
module reg_rename_file #(
  parameter int TAG_WIDTH = 4,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_en_1,
  input  logic [4:0]           read_addr_1,
  output logic                 read_is_ref_1,
  output logic [31:0]          read_data_1,
  input  logic                 read_en_2,
  input  logic [4:0]           read_addr_2,
  output logic                 read_is_ref_2,
  output logic [31:0]          read_data_2,
  input  logic                 rename_en,
  input  logic [4:0]           rename_addr,
  input  logic [TAG_WIDTH-1:0] rename_tag,
  input  logic                 commit_en,
  input  logic [4:0]           commit_addr,
  input  logic [TAG_WIDTH-1:0] commit_tag,
  input  logic [31:0]          commit_data,
  input  logic                 flush
);

  logic [31:0]          r_value [REG_COUNT];
  logic [REG_COUNT-1:0] r_ref;
  logic [TAG_WIDTH-1:0] r_tag   [REG_COUNT];

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_reg
    logic w_cmt_sel;
    logic w_ren_sel;
    assign w_cmt_sel = commit_en && (commit_addr == 5'(g)) && (g != 0);
    assign w_ren_sel = rename_en && (rename_addr == 5'(g)) && (g != 0);

    // ref priority: flush > rename > matching commit clears > hold
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_value[g] <= '0;
        r_ref[g]   <= 1'b0;
        r_tag[g]   <= '0;
      end else begin
        if (w_cmt_sel) begin
          r_value[g] <= commit_data;
        end
        if (flush) begin
          r_ref[g] <= 1'b0;
        end else if (w_ren_sel) begin
          r_ref[g] <= 1'b1;
          r_tag[g] <= rename_tag;
        end else if (w_cmt_sel && r_ref[g] && (r_tag[g] == commit_tag)) begin
          r_ref[g] <= 1'b0;
        end
      end
    end
  end

  logic        w_rd_en     [2];
  logic [4:0]  w_rd_addr   [2];
  logic        w_rd_is_ref [2];
  logic [31:0] w_rd_data   [2];

  assign w_rd_en[0]   = read_en_1;
  assign w_rd_addr[0] = read_addr_1;
  assign w_rd_en[1]   = read_en_2;
  assign w_rd_addr[1] = read_addr_2;

  for (genvar p = 0; p < 2; p++) begin : g_port
    always_comb begin
      w_rd_is_ref[p] = 1'b0;
      w_rd_data[p]   = '0;
      if (w_rd_en[p] && (w_rd_addr[p] != 5'd0)) begin
        // A retiring producer forwards its result before the ref bit clears
        if (commit_en && (commit_addr == w_rd_addr[p]) && r_ref[w_rd_addr[p]] &&
            (r_tag[w_rd_addr[p]] == commit_tag)) begin
          w_rd_data[p] = commit_data;
        end else if (r_ref[w_rd_addr[p]]) begin
          w_rd_is_ref[p] = 1'b1;
          w_rd_data[p]   = 32'(r_tag[w_rd_addr[p]]);
        end else begin
          w_rd_data[p] = r_value[w_rd_addr[p]];
        end
      end
    end
  end

  assign read_is_ref_1 = w_rd_is_ref[0];
  assign read_data_1   = w_rd_data[0];
  assign read_is_ref_2 = w_rd_is_ref[1];
  assign read_data_2   = w_rd_data[1];

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file: hand-computed {is_ref, data} expectations on both read ports.
module tb_reg_rename_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en_1, read_en_2;
  logic [4:0]  read_addr_1, read_addr_2;
  logic        read_is_ref_1, read_is_ref_2;
  logic [31:0] read_data_1, read_data_2;
  logic        rename_en, commit_en, flush;
  logic [4:0]  rename_addr, commit_addr;
  logic [3:0]  rename_tag, commit_tag;
  logic [31:0] commit_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_rename_file #(.TAG_WIDTH(4), .REG_COUNT(32)) dut (
    .clk(clk), .rst(rst),
    .read_en_1(read_en_1), .read_addr_1(read_addr_1),
    .read_is_ref_1(read_is_ref_1), .read_data_1(read_data_1),
    .read_en_2(read_en_2), .read_addr_2(read_addr_2),
    .read_is_ref_2(read_is_ref_2), .read_data_2(read_data_2),
    .rename_en(rename_en), .rename_addr(rename_addr), .rename_tag(rename_tag),
    .commit_en(commit_en), .commit_addr(commit_addr), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush)
  );

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got is_ref=%0b data=%08h, expected is_ref=%0b data=%08h",
               tag, got[32], got[31:0], exp[32], exp[31:0]);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rename_en = 1'b0; commit_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    read_en_1 = 1'b1; read_addr_1 = 5'd5;
    read_en_2 = 1'b1; read_addr_2 = 5'd3;
    rename_en = 1'b0; rename_addr = '0; rename_tag = '0;
    commit_en = 1'b0; commit_addr = '0; commit_tag = '0; commit_data = '0;
    flush = 1'b0;
    #2;
    chk("reset_p1_r5", {read_is_ref_1, read_data_1}, {1'b0, 32'h0});
    chk("reset_p2_r3", {read_is_ref_2, read_data_2}, {1'b0, 32'h0});
    #10 rst = 1'b1;
    tick();

    // Rename r3 tag 7: invisible same cycle, visible next cycle
    read_addr_1 = 5'd3;
    rename_en = 1'b1; rename_addr = 5'd3; rename_tag = 4'd7;
    #1 chk("rename_same_cycle", {read_is_ref_1, read_data_1}, {1'b0, 32'h0});
    tick(); idle();
    #1 chk("rename_next_cycle", {read_is_ref_1, read_data_1}, {1'b1, 32'h7});
    read_en_2 = 1'b0;
    #1 chk("p2_disabled", {read_is_ref_2, read_data_2}, {1'b0, 32'h0});
    read_en_2 = 1'b1;

    // Commit r3 tag 7: bypass then stored
    commit_en = 1'b1; commit_addr = 5'd3; commit_tag = 4'd7; commit_data = 32'hDEADBEEF;
    #1 chk("commit_bypass", {read_is_ref_1, read_data_1}, {1'b0, 32'hDEADBEEF});
    chk("commit_bypass_p2", {read_is_ref_2, read_data_2}, {1'b0, 32'hDEADBEEF});
    tick(); idle();
    #1 chk("commit_stored", {read_is_ref_1, read_data_1}, {1'b0, 32'hDEADBEEF});

    // Stale commit on r4 must not clear a younger rename
    read_addr_1 = 5'd4; read_addr_2 = 5'd4;
    rename_en = 1'b1; rename_addr = 5'd4; rename_tag = 4'd2;
    tick();
    rename_tag = 4'd9;
    tick(); idle();
    commit_en = 1'b1; commit_addr = 5'd4; commit_tag = 4'd2; commit_data = 32'h11;
    #1 chk("stale_commit_no_bypass", {read_is_ref_1, read_data_1}, {1'b1, 32'h9});
    tick(); idle();
    #1 chk("stale_commit_keeps_ref", {read_is_ref_1, read_data_1}, {1'b1, 32'h9});
    commit_en = 1'b1; commit_tag = 4'd9; commit_data = 32'h22;
    #1 chk("young_commit_bypass", {read_is_ref_2, read_data_2}, {1'b0, 32'h22});
    tick(); idle();
    #1 chk("young_commit_clears", {read_is_ref_1, read_data_1}, {1'b0, 32'h22});

    // r6: commit tag 1 and rename tag 3 on the same edge; rename wins, then flush
    read_addr_1 = 5'd6;
    rename_en = 1'b1; rename_addr = 5'd6; rename_tag = 4'd1;
    tick(); idle();
    commit_en = 1'b1; commit_addr = 5'd6; commit_tag = 4'd1; commit_data = 32'h55;
    rename_en = 1'b1; rename_addr = 5'd6; rename_tag = 4'd3;
    #1 chk("commit_rename_bypass", {read_is_ref_1, read_data_1}, {1'b0, 32'h55});
    tick(); idle();
    #1 chk("rename_beats_commit", {read_is_ref_1, read_data_1}, {1'b1, 32'h3});
    flush = 1'b1;
    tick(); idle();
    #1 chk("flush_exposes_value", {read_is_ref_1, read_data_1}, {1'b0, 32'h55});

    // Writes to r0 are ignored
    read_addr_1 = 5'd0;
    rename_en = 1'b1; rename_addr = 5'd0; rename_tag = 4'd5;
    commit_en = 1'b1; commit_addr = 5'd0; commit_tag = 4'd5; commit_data = 32'hFFFF;
    #1 chk("r0_same_cycle", {read_is_ref_1, read_data_1}, {1'b0, 32'h0});
    tick(); idle();
    #1 chk("r0_after_write", {read_is_ref_1, read_data_1}, {1'b0, 32'h0});

    // Flush discards a concurrent rename
    read_addr_1 = 5'd8;
    flush = 1'b1; rename_en = 1'b1; rename_addr = 5'd8; rename_tag = 4'd4;
    tick(); idle();
    #1 chk("flush_drops_rename", {read_is_ref_1, read_data_1}, {1'b0, 32'h0});

    // Flush still lets a concurrent commit write the value
    read_addr_2 = 5'd9;
    rename_en = 1'b1; rename_addr = 5'd9; rename_tag = 4'd6;
    tick(); idle();
    #1 chk("r9_renamed", {read_is_ref_2, read_data_2}, {1'b1, 32'h6});
    flush = 1'b1;
    commit_en = 1'b1; commit_addr = 5'd9; commit_tag = 4'd6; commit_data = 32'h99;
    tick(); idle();
    #1 chk("flush_keeps_commit", {read_is_ref_2, read_data_2}, {1'b0, 32'h99});

    // Asynchronous reset mid-run with r5 referenced
    read_addr_1 = 5'd5; read_addr_2 = 5'd3;
    rename_en = 1'b1; rename_addr = 5'd5; rename_tag = 4'd2;
    tick(); idle();
    #1 chk("r5_renamed", {read_is_ref_1, read_data_1}, {1'b1, 32'h2});
    rst = 1'b0;
    #1 chk("async_reset_p1", {read_is_ref_1, read_data_1}, {1'b0, 32'h0});
    chk("async_reset_p2", {read_is_ref_2, read_data_2}, {1'b0, 32'h0});
    #2 rst = 1'b1;
    tick();
    #1 chk("after_reset_r3", {read_is_ref_2, read_data_2}, {1'b0, 32'h0});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Architectural register file plus register alias state for the OOPA core. Sits in the ID stage and answers the two register read ports driven by the operand/regfile-address generator.
- Each register holds either a committed value or a reference (ROB tag) to the in-flight producer.
- ID-stage destination writes allocate references. ROB commits write values back and retire matching references.
- Pipeline flush drops all references.

Parameters:
- TAG_WIDTH, 4, width of ROB tag stored as a reference (must be ≤ 32).
- REG_COUNT, 32, number of architectural registers (address width 5).

Ports:
- clk  in  1  core clock, all state updated on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- read_en_1  in  1  read port 1 enable
- read_addr_1  in  5  read port 1 register address
- read_is_ref_1  out  1  1: read_data_1 carries a ROB tag; 0: carries a value
- read_data_1  out  32  value, or {zero pad, tag} when read_is_ref_1=1
- read_en_2, read_addr_2, read_is_ref_2, read_data_2  same as port 1, for port 2
- rename_en  in  1  ID stage issues a destination write this cycle (qualified by ID not stalled)
- rename_addr  in  5  destination register
- rename_tag  in  TAG_WIDTH  ROB tag allocated to that instruction
- commit_en  in  1  ROB retires a register-writing instruction
- commit_addr  in  5  committed destination register
- commit_tag  in  TAG_WIDTH  ROB tag of retiring instruction
- commit_data  in  32  committed result
- flush  in  1  pipeline flush (exception/mispredict recovery)

Behaviour:
- State per register r:
  - value[r] (32 bits)
  - ref[r] (1 bit)
  - tag[r] (TAG_WIDTH bits)
- Reset (rst=0, asynchronous): all value, ref and tag cleared to 0 immediately.
- Outputs are combinational, so during reset every read returns is_ref=0, data=0.
- Read ports are combinational (0-cycle latency) and both ports are independent and identical. Priority per port:
  1. read_en=0 → is_ref=0, data=0.
  2. addr=0 → is_ref=0, data=0. $zero never holds a reference.
  3. commit bypass: commit_en=1, commit_addr=addr, ref[addr]=1 and tag[addr]=commit_tag → is_ref=0, data=commit_data.
  4. ref[addr]=1 → is_ref=1, data={0, tag[addr]}.
  5. otherwise → is_ref=0, data=value[addr].
- Reads never observe a same-cycle rename. The rename takes effect from the next cycle.
- Commit (rising edge, commit_en=1, commit_addr≠0):
  - value[commit_addr] ← commit_data, unconditionally.
  - If ref[commit_addr]=1 and tag[commit_addr]=commit_tag, ref[commit_addr] ← 0.
  - A tag mismatch means a younger rename owns the register; ref and tag are unchanged.
- Rename (rising edge, rename_en=1, rename_addr≠0): ref[rename_addr] ← 1, tag[rename_addr] ← rename_tag.
- Writes addressed to register 0 (rename or commit) are ignored entirely.
- Simultaneous commit and rename to the same register:
  - value is updated with commit_data.
  - Rename wins: ref=1, tag=rename_tag.
- Flush (rising edge, flush=1):
  - All ref bits ← 0; tags are don't-care.
  - A same-cycle commit still updates value.
  - A same-cycle rename is discarded; flush has priority over rename.
- Combined priority for ref[r] at the edge: flush > rename > commit-clear > hold.
- No handshake or backpressure. The ROB guarantees commit_tag uniqueness among live tags; the block does not check tag collisions.

Test Plan:
- Reset then read_en_1=1, addr=5 → is_ref_1=0, data_1=0. Assert rst=0 mid-run with ref[5] set → outputs drop to 0 the same cycle, before the next clk edge.
- Rename r3 with tag 7, then read r3 next cycle → is_ref=1, data=0x00000007. Same-cycle read during the rename → is_ref=0, old value.
- r3 ref tag 7, commit r3 tag 7, data 0xDEADBEEF:
  - same-cycle read → is_ref=0, 0xDEADBEEF (bypass);
  - next cycle → is_ref=0, 0xDEADBEEF.
- Rename r4 tag 2, rename r4 tag 9, commit r4 tag 2, data 0x11 → r4 stays is_ref=1, data=9. Then commit tag 9, data 0x22 → value 0x22, ref cleared.
- Same edge: commit r6 tag 1, data 0x55 (ref tag 1) and rename r6 tag 3 → next read is_ref=1, data=3. After flush → is_ref=0, data=0x55.
- Rename r0 tag 5 and commit r0, data 0xFFFF → read r0 returns is_ref=0, data=0. Flush with concurrent rename r8 → r8 not referenced afterwards.
